// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_ctrl_pkg;

    // Arbiter state: idle, long request blocked, CPU stalled to force the long write
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } arb_state_t;

    // Architectural zero register, never written
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-unit destinations with two hazard lookups.
// Latency: set/clear take effect the cycle after the edge; lookups are combinational on state.
// Backpressure: none; set wins over clear on the same register in the same cycle.
module rf_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          set_en,
    input  logic [AW-1:0] set_reg,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_reg,
    input  logic [AW-1:0] rd1,
    input  logic [AW-1:0] rd2,
    output logic          hazard
);

    localparam logic [AW-1:0] REG0 = AW'(REG_ZERO);

    logic [2**AW-1:0] pending;

    // Clear on long commit, then set on issue so a same-edge set overrides the clear
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clr_en && (clr_reg != REG0)) begin
                pending[clr_reg] <= 1'b0;
            end
            if (set_en && (set_reg != REG0)) begin
                pending[set_reg] <= 1'b1;
            end
        end
    end

    // Hazard lookup from registered state: stays high through the commit cycle
    always_comb begin
        hazard = (pending[rd1] && (rd1 != REG0)) || (pending[rd2] && (rd2 != REG0));
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between the ALU and a long unit; tracks pending long writes.
// Latency: grant and write controls are combinational, written at the next clock edge.
// Backpressure: ALU has priority; a long request blocked MAX_WAIT cycles forces Stall until it commits.
module regfile_write_arbiter
    import regfile_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int AW       = 5,
    parameter int DW       = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          AluWrite,
    input  logic [AW-1:0] AluReg,
    input  logic [DW-1:0] AluData,
    input  logic          LongValid,
    input  logic [AW-1:0] LongReg,
    input  logic [DW-1:0] LongData,
    output logic          LongReady,
    input  logic          Issue,
    input  logic [AW-1:0] IssueReg,
    input  logic [AW-1:0] Read1,
    input  logic [AW-1:0] Read2,
    output logic          Hazard,
    output logic          Stall,
    output logic          RegWrite,
    output logic [AW-1:0] WriteReg,
    output logic [DW-1:0] WriteData
);

    localparam int            CW      = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);
    localparam logic [AW-1:0] REG0    = AW'(REG_ZERO);

    arb_state_t    state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [CW-1:0] cnt_inc;
    logic          alu_win;
    logic          handshake;
    logic          sb_hazard;

    // State register and blocked-cycle counter
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant mux: ALU first unless stalled, long unit otherwise; reg 0 handshakes without writing
    always_comb begin
        Stall     = 1'b0;
        LongReady = 1'b0;
        RegWrite  = 1'b0;
        WriteReg  = '0;
        WriteData = '0;
        alu_win   = 1'b0;
        if (!reset) begin
            Stall   = (state == ST_FORCE);
            alu_win = !Stall && AluWrite && (AluReg != REG0);
            if (alu_win) begin
                RegWrite  = 1'b1;
                WriteReg  = AluReg;
                WriteData = AluData;
            end else if (LongValid) begin
                LongReady = 1'b1;
                if (LongReg != REG0) begin
                    RegWrite  = 1'b1;
                    WriteReg  = LongReg;
                    WriteData = LongData;
                end
            end
        end
        handshake = LongValid && LongReady;
    end

    // Next state: count consecutive blocked cycles and force a stall once the bound is reached;
    // a dropped LongValid returns to idle so the CPU can never be left frozen
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        cnt_inc   = cnt + CNT_ONE;
        case (state)
            ST_IDLE: begin
                if (LongValid && !LongReady) begin
                    cnt_nxt   = CNT_ONE;
                    state_nxt = (CNT_ONE == CNT_MAX) ? ST_FORCE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (handshake || !LongValid) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_nxt = ST_FORCE;
                    end
                end
            end
            ST_FORCE: begin
                if (handshake || !LongValid) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    rf_scoreboard #(
        .AW(AW)
    ) u_scoreboard (
        .clock   (clock),
        .reset   (reset),
        .set_en  (Issue),
        .set_reg (IssueReg),
        .clr_en  (handshake),
        .clr_reg (LongReg),
        .rd1     (Read1),
        .rd2     (Read2),
        .hazard  (sb_hazard)
    );

    // Hazard is masked while reset is held
    always_comb begin
        Hazard = sb_hazard && !reset;
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized bench for regfile_write_arbiter against a behavioural reference model.
// Latency: outputs sampled 1 time unit after inputs change, mid-cycle away from the rising edge.
// Backpressure: the long unit holds its request stable until handshake, as a real producer would.
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;
    localparam int AW       = 5;
    localparam int DW       = 32;

    logic          clock;
    logic          reset;
    logic          AluWrite;
    logic [AW-1:0] AluReg;
    logic [DW-1:0] AluData;
    logic          LongValid;
    logic [AW-1:0] LongReg;
    logic [DW-1:0] LongData;
    logic          LongReady;
    logic          Issue;
    logic [AW-1:0] IssueReg;
    logic [AW-1:0] Read1;
    logic [AW-1:0] Read2;
    logic          Hazard;
    logic          Stall;
    logic          RegWrite;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;

    regfile_write_arbiter #(
        .MAX_WAIT(MAX_WAIT),
        .AW(AW),
        .DW(DW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .AluWrite  (AluWrite),
        .AluReg    (AluReg),
        .AluData   (AluData),
        .LongValid (LongValid),
        .LongReg   (LongReg),
        .LongData  (LongData),
        .LongReady (LongReady),
        .Issue     (Issue),
        .IssueReg  (IssueReg),
        .Read1     (Read1),
        .Read2     (Read2),
        .Hazard    (Hazard),
        .Stall     (Stall),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count of consecutive cycles the current long request went unserved,
    // and the set of registers with an outstanding long write
    int blocked = 0;
    bit pend [2**AW];
    bit m_hs;
    bit last_hs = 1'b1;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Compare every output against what the rules say for the current inputs and model state
    task automatic model_check();
        bit e_stall, alu_win, e_lready, e_rw, e_haz;
        #1;
        e_stall  = !reset && (blocked >= MAX_WAIT);
        alu_win  = !reset && !e_stall && AluWrite && (AluReg != 0);
        e_lready = !reset && !alu_win && LongValid;
        e_rw     = alu_win || (e_lready && (LongReg != 0));
        e_haz    = !reset && ((pend[Read1] && Read1 != 0) || (pend[Read2] && Read2 != 0));
        m_hs     = LongValid && e_lready;
        chk("stall", DW'(Stall), DW'(e_stall));
        chk("long_ready", DW'(LongReady), DW'(e_lready));
        chk("reg_write", DW'(RegWrite), DW'(e_rw));
        chk("hazard", DW'(Hazard), DW'(e_haz));
        if (e_rw) begin
            chk("write_reg", DW'(WriteReg), alu_win ? DW'(AluReg) : DW'(LongReg));
            chk("write_data", WriteData, alu_win ? AluData : LongData);
        end else if (!reset && !LongValid && !(AluWrite && AluReg != 0)) begin
            chk("idle_reg", DW'(WriteReg), '0);
            chk("idle_data", WriteData, '0);
        end
    endtask

    // Advance one clock and apply the rules to the model state
    task automatic tick();
        @(posedge clock);
        if (reset) begin
            blocked = 0;
            foreach (pend[i]) pend[i] = 1'b0;
            last_hs = 1'b0;
        end else begin
            if (m_hs || !LongValid) blocked = 0;
            else blocked++;
            if (m_hs) pend[LongReg] = 1'b0;
            if (Issue && IssueReg != 0) pend[IssueReg] = 1'b1;
            last_hs = m_hs;
        end
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        foreach (pend[i]) pend[i] = 1'b0;
        reset = 1'b1; AluWrite = 1'b1; AluReg = 5'd8; AluData = 32'd3;
        LongValid = 1'b1; LongReg = 5'd9; LongData = 32'd35;
        Issue = 1'b1; IssueReg = 5'd7; Read1 = 5'd7; Read2 = 5'd0;
        @(negedge clock);

        // 1: reset held with requests present
        for (int i = 0; i < 2; i++) begin
            model_check();
            chk("rst_regwrite", DW'(RegWrite), '0);
            chk("rst_longready", DW'(LongReady), '0);
            chk("rst_stall", DW'(Stall), '0);
            chk("rst_hazard", DW'(Hazard), '0);
            tick();
        end
        reset = 1'b0; LongValid = 1'b0; Issue = 1'b0;

        // 2: plain ALU write, then ALU write to reg 0
        model_check();
        chk("alu_we", DW'(RegWrite), 32'd1);
        chk("alu_reg", DW'(WriteReg), 32'd8);
        chk("alu_data", WriteData, 32'd3);
        tick();
        AluReg = 5'd0;
        model_check();
        chk("alu_r0_we", DW'(RegWrite), '0);
        tick();

        // 3: ALU hogs the port; long request forced through after MAX_WAIT blocked cycles
        AluReg = 5'd12; AluData = 32'd7;
        LongValid = 1'b1; LongReg = 5'd9; LongData = 32'd35;
        for (int i = 0; i < MAX_WAIT; i++) begin
            model_check();
            chk("blocked_ready", DW'(LongReady), '0);
            chk("blocked_reg", DW'(WriteReg), 32'd12);
            tick();
        end
        model_check();
        chk("force_stall", DW'(Stall), 32'd1);
        chk("force_we", DW'(RegWrite), 32'd1);
        chk("force_reg", DW'(WriteReg), 32'd9);
        chk("force_data", WriteData, 32'd35);
        chk("force_ready", DW'(LongReady), 32'd1);
        tick();
        LongValid = 1'b0;
        model_check();
        chk("after_force_stall", DW'(Stall), '0);
        tick();

        // 4: issue reg 10, hazard until one cycle after the commit
        AluWrite = 1'b0; Issue = 1'b1; IssueReg = 5'd10; Read1 = 5'd0;
        model_check();
        tick();
        Issue = 1'b0; Read1 = 5'd10;
        model_check();
        chk("haz_pending", DW'(Hazard), 32'd1);
        tick();
        LongValid = 1'b1; LongReg = 5'd10; LongData = 32'h55;
        model_check();
        chk("haz_commit", DW'(Hazard), 32'd1);
        chk("commit_ready", DW'(LongReady), 32'd1);
        tick();
        LongValid = 1'b0;
        model_check();
        chk("haz_cleared", DW'(Hazard), '0);
        tick();

        // 5: issue and commit of reg 11 on the same edge; set wins
        Read1 = 5'd0; Issue = 1'b1; IssueReg = 5'd11;
        LongValid = 1'b1; LongReg = 5'd11; LongData = 32'h66;
        model_check();
        tick();
        Issue = 1'b0; LongValid = 1'b0; Read2 = 5'd11;
        model_check();
        chk("set_wins", DW'(Hazard), 32'd1);
        tick();
        LongValid = 1'b1;
        model_check();
        tick();
        LongValid = 1'b0; Read2 = 5'd0;

        // 6: reset asserted while in FORCE with reg 13 pending
        Issue = 1'b1; IssueReg = 5'd13;
        AluWrite = 1'b1; AluReg = 5'd12;
        LongValid = 1'b1; LongReg = 5'd14; LongData = 32'h77;
        for (int i = 0; i < MAX_WAIT; i++) begin
            model_check();
            tick();
            Issue = 1'b0; Read1 = 5'd13;
        end
        model_check();
        chk("pre_rst_stall", DW'(Stall), 32'd1);
        chk("pre_rst_haz", DW'(Hazard), 32'd1);
        reset = 1'b1;
        model_check();
        tick();
        reset = 1'b0;
        model_check();
        chk("post_rst_stall", DW'(Stall), '0);
        chk("post_rst_haz", DW'(Hazard), '0);
        tick();
        LongValid = 1'b0; AluWrite = 1'b0;
        model_check();
        tick();

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 59) == 0);
            AluWrite = ($urandom_range(0, 9) < 7);
            AluReg   = AW'($urandom_range(0, 7));
            AluData  = $urandom;
            if (!LongValid || last_hs) begin
                LongValid = ($urandom_range(0, 2) != 0);
                LongReg   = AW'($urandom_range(0, 7));
                LongData  = $urandom;
            end
            Issue    = ($urandom_range(0, 2) == 0);
            IssueReg = AW'($urandom_range(0, 7));
            Read1    = AW'($urandom_range(0, 7));
            Read2    = AW'($urandom_range(0, 7));
            model_check();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
